ac_motor_ramp_sequencer: RTL and testbench

AC_MOTOR_RAMP_SEQUENCER -- requirements
Module: ac_motor_ramp_sequencer

---
 rtl/ac_motor_pkg.sv | 20 ++
 rtl/ac_motor_tick_gen.sv | 29 ++
 rtl/ac_motor_ramp_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ac_motor_ramp_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor ramp sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package ac_motor_pkg;

    localparam int RES_BITS_DEF = 12;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP    = 3'd1,
        ST_RUN     = 3'd2,
        ST_REVERSE = 3'd3,
        ST_DEAD    = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

endpackage

// File: rtl/ac_motor_tick_gen.sv
// Free-running prescaler: TICK is high for one clock every STEP_DIV clocks.
// Latency: first TICK is seen on the STEP_DIV-th rising edge after RESET releases.
// Backpressure: none; runs continuously.
module ac_motor_tick_gen #(
    parameter int STEP_DIV = 1024
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);
    localparam int                CNT_W   = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Combinational so the sequencer steps on the same edge the count wraps.
    assign TICK = (cnt == CNT_MAX);

endmodule

// File: rtl/ac_motor_ramp_sequencer.sv
// AC motor soft start/stop, reversal and fault lockout; AC_MOTOR_DEADTIME_EN adds a dead band on reversal.
// Latency: all outputs registered, one clock from input to state change; POWER moves only on prescaler ticks.
// Backpressure: none; inputs are levels sampled every clock.
module ac_motor_ramp_sequencer
    import ac_motor_pkg::*;
#(
    parameter int resolution_bits = RES_BITS_DEF,
    parameter int STEP_DIV        = 1024,
    parameter int STEP_SIZE       = 1,
    parameter int DEADTIME        = 256
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       ENABLE,
    input  logic [resolution_bits-1:0] TARGET,
    input  logic                       DIR_REQ,
    input  logic                       FAULT_IN,
    output logic [resolution_bits-1:0] POWER,
    output logic                       CW,
    output logic                       CCW,
    output logic [2:0]                 STATE,
    output logic                       AT_TARGET,
    output logic                       BUSY
);
    localparam int         W      = resolution_bits;
    localparam logic [W:0] STEP_W = (W+1)'(STEP_SIZE);

    state_t       state_q, state_nxt;
    logic [W-1:0] power_q, power_nxt, eff, step_toward, step_down;
    logic [W:0]   pwr_w, eff_w, sum_up, diff_dn;
    logic         dir_q, dir_nxt, tick, drive, busy_nxt;
    logic         cw_q, ccw_q, at_target_q, busy_q;

`ifdef AC_MOTOR_DEADTIME_EN
    localparam int               DT_W    = $clog2(DEADTIME + 1);
    localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADTIME - 1);
    logic [DT_W-1:0] dead_q, dead_nxt;
`else
    logic unused_deadtime;
    assign unused_deadtime = (DEADTIME != 0);
`endif

    ac_motor_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick)
    );

    // One extra bit of headroom so neither direction of step can wrap.
    assign eff     = ENABLE ? TARGET : '0;
    assign pwr_w   = {1'b0, power_q};
    assign eff_w   = {1'b0, eff};
    assign sum_up  = pwr_w + STEP_W;
    assign diff_dn = pwr_w - STEP_W;

    always_comb begin
        step_toward = eff;
        if (pwr_w < eff_w) begin
            if (sum_up < eff_w) step_toward = sum_up[W-1:0];
        end else if (pwr_w > eff_w + STEP_W) begin
            step_toward = diff_dn[W-1:0];
        end
        step_down = '0;
        if (pwr_w > STEP_W) step_down = diff_dn[W-1:0];
    end

    always_comb begin
        state_nxt = state_q;
        power_nxt = power_q;
        dir_nxt   = dir_q;
`ifdef AC_MOTOR_DEADTIME_EN
        dead_nxt  = dead_q;
`endif
        if (FAULT_IN) begin
            state_nxt = ST_FAULT;
            power_nxt = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    power_nxt = '0;
                    if (ENABLE && (TARGET != '0)) begin
                        dir_nxt   = DIR_REQ;
                        state_nxt = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (DIR_REQ != dir_q) begin
                        state_nxt = ST_REVERSE;
                    end else if (power_q == eff) begin
                        state_nxt = (eff != '0) ? ST_RUN : ST_IDLE;
                    end else if (tick) begin
                        power_nxt = step_toward;
                        if (step_toward == eff) state_nxt = (eff != '0) ? ST_RUN : ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (DIR_REQ != dir_q)   state_nxt = ST_REVERSE;
                    else if (eff != power_q) state_nxt = ST_RAMP;
                end
                ST_REVERSE: begin
                    if (tick) power_nxt = step_down;
                    if (power_nxt == '0) begin
`ifdef AC_MOTOR_DEADTIME_EN
                        state_nxt = ST_DEAD;
                        dead_nxt  = DT_LOAD;
`else
                        dir_nxt   = ~dir_q;
                        state_nxt = (eff == '0) ? ST_IDLE : ST_RAMP;
`endif
                    end
                end
`ifdef AC_MOTOR_DEADTIME_EN
                ST_DEAD: begin
                    power_nxt = '0;
                    if (dead_q == '0) begin
                        dir_nxt   = ~dir_q;
                        state_nxt = (eff == '0) ? ST_IDLE : ST_RAMP;
                    end else begin
                        dead_nxt = dead_q - 1'b1;
                    end
                end
`endif
                ST_FAULT: begin
                    power_nxt = '0;
                    if (!ENABLE) state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    power_nxt = '0;
                end
            endcase
        end
    end

    // Direction outputs follow the old latched direction until the swap.
    assign drive    = (state_nxt == ST_RAMP) || (state_nxt == ST_RUN) || (state_nxt == ST_REVERSE);
    assign busy_nxt = (state_nxt == ST_RAMP) || (state_nxt == ST_REVERSE) || (state_nxt == ST_DEAD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            power_q     <= '0;
            dir_q       <= DIR_CW;
            cw_q        <= 1'b0;
            ccw_q       <= 1'b0;
            at_target_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AC_MOTOR_DEADTIME_EN
            dead_q      <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            power_q     <= power_nxt;
            dir_q       <= dir_nxt;
            cw_q        <= drive && (dir_nxt == DIR_CW);
            ccw_q       <= drive && (dir_nxt == DIR_CCW);
            at_target_q <= (state_nxt == ST_RUN);
            busy_q      <= busy_nxt;
`ifdef AC_MOTOR_DEADTIME_EN
            dead_q      <= dead_nxt;
`endif
        end
    end

    assign POWER     = power_q;
    assign CW        = cw_q;
    assign CCW       = ccw_q;
    assign STATE     = state_q;
    assign AT_TARGET = at_target_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_ac_motor_ramp_sequencer.sv
// Directed bench for ac_motor_ramp_sequencer (STEP_DIV=4, STEP_SIZE=16, DEADTIME=8).
// Dead-band expectations follow AC_MOTOR_DEADTIME_EN as seen by this compile.
module tb_ac_motor_ramp_sequencer;
    localparam int RB = 12;
`ifdef AC_MOTOR_DEADTIME_EN
    localparam int DT = 8;
`else
    localparam int DT = 0;
`endif

    logic          CLK = 1'b0;
    logic          RESET, ENABLE, DIR_REQ, FAULT_IN;
    logic [RB-1:0] TARGET, POWER;
    logic          CW, CCW, AT_TARGET, BUSY;
    logic [2:0]    STATE;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    ac_motor_ramp_sequencer #(
        .resolution_bits (RB),
        .STEP_DIV        (4),
        .STEP_SIZE       (16),
        .DEADTIME        (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .TARGET    (TARGET),
        .DIR_REQ   (DIR_REQ),
        .FAULT_IN  (FAULT_IN),
        .POWER     (POWER),
        .CW        (CW),
        .CCW       (CCW),
        .STATE     (STATE),
        .AT_TARGET (AT_TARGET),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // Rising edges since reset release; ticks land on multiples of 4.
    always @(posedge CLK) begin
        if (RESET) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_reset;
        @(posedge CLK);
        #1;
        ENABLE = 0; TARGET = 0; DIR_REQ = 0; FAULT_IN = 0; RESET = 1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 0;
    endtask

    task automatic go_run64;
        apply_reset();
        ENABLE = 1; TARGET = 64; DIR_REQ = 0;
        wait_edge(16);
        checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL setup_run64 state got=%0d exp=2", STATE); end
    endtask

    task automatic test_reset;
        ENABLE = 0; TARGET = 0; DIR_REQ = 0; FAULT_IN = 0; RESET = 0;
        #2;
        RESET = 1;
        #1;
        checks++; if (POWER !== 12'd0) begin errors++; $display("FAIL reset_power got=%0d exp=0", POWER); end
        checks++; if ({CW, CCW} !== 2'b00) begin errors++; $display("FAIL reset_dir got=%b exp=00", {CW, CCW}); end
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", STATE); end
        checks++; if ({AT_TARGET, BUSY} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {AT_TARGET, BUSY}); end
        @(posedge CLK);
        #1;
        RESET = 0;
        wait_edge(2);
        checks++; if (STATE !== 3'd0 || POWER !== 12'd0) begin errors++; $display("FAIL idle_hold state=%0d power=%0d exp 0/0", STATE, POWER); end
    endtask

    task automatic test_ramp_up;
        apply_reset();
        ENABLE = 1; TARGET = 64; DIR_REQ = 0;
        wait_edge(1);
        checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL up_start_state got=%0d exp=1", STATE); end
        checks++; if ({CW, CCW, BUSY} !== 3'b101) begin errors++; $display("FAIL up_start_flags cw,ccw,busy got=%b exp=101", {CW, CCW, BUSY}); end
        for (int k = 1; k <= 4; k++) begin
            wait_edge(4 * k - 1);
            checks++; if (POWER !== RB'(16 * (k - 1))) begin errors++; $display("FAIL up_hold edge=%0d got=%0d exp=%0d", edge_n, POWER, 16 * (k - 1)); end
            wait_edge(4 * k);
            checks++; if (POWER !== RB'(16 * k)) begin errors++; $display("FAIL up_step edge=%0d got=%0d exp=%0d", edge_n, POWER, 16 * k); end
        end
        checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL up_run_state got=%0d exp=2", STATE); end
        checks++; if ({AT_TARGET, BUSY, CW} !== 3'b101) begin errors++; $display("FAIL up_run_flags at,busy,cw got=%b exp=101", {AT_TARGET, BUSY, CW}); end
    endtask

    task automatic test_target_step;
        go_run64();
        TARGET = 70;
        wait_edge(17);
        checks++; if (STATE !== 3'd1 || AT_TARGET !== 1'b0) begin errors++; $display("FAIL step_enter state=%0d at=%b exp 1/0", STATE, AT_TARGET); end
        wait_edge(19);
        checks++; if (POWER !== 12'd64) begin errors++; $display("FAIL step_hold got=%0d exp=64", POWER); end
        wait_edge(20);
        checks++; if (POWER !== 12'd70) begin errors++; $display("FAIL step_sat got=%0d exp=70", POWER); end
        checks++; if (STATE !== 3'd2 || AT_TARGET !== 1'b1) begin errors++; $display("FAIL step_run state=%0d at=%b exp 2/1", STATE, AT_TARGET); end
        wait_edge(28);
        checks++; if (POWER !== 12'd70) begin errors++; $display("FAIL step_stable got=%0d exp=70", POWER); end
    endtask

    task automatic test_reverse;
        go_run64();
        DIR_REQ = 1;
        wait_edge(17);
        checks++; if (STATE !== 3'd3 || {CW, CCW} !== 2'b10) begin errors++; $display("FAIL rev_enter state=%0d dir=%b exp 3/10", STATE, {CW, CCW}); end
        for (int k = 1; k <= 3; k++) begin
            wait_edge(16 + 4 * k);
            checks++; if (POWER !== RB'(64 - 16 * k) || CW !== 1'b1) begin errors++; $display("FAIL rev_down edge=%0d power=%0d cw=%b exp %0d/1", edge_n, POWER, CW, 64 - 16 * k); end
        end
        wait_edge(32);
        checks++; if (POWER !== 12'd0 || CW !== 1'b0) begin errors++; $display("FAIL rev_zero power=%0d cw=%b exp 0/0", POWER, CW); end
`ifdef AC_MOTOR_DEADTIME_EN
        checks++; if (STATE !== 3'd4 || CCW !== 1'b0) begin errors++; $display("FAIL dead_enter state=%0d ccw=%b exp 4/0", STATE, CCW); end
        wait_edge(39);
        checks++; if (STATE !== 3'd4 || {CW, CCW} !== 2'b00) begin errors++; $display("FAIL dead_hold state=%0d dir=%b exp 4/00", STATE, {CW, CCW}); end
        wait_edge(40);
        checks++; if (STATE !== 3'd1 || {CW, CCW} !== 2'b01) begin errors++; $display("FAIL dead_exit state=%0d dir=%b exp 1/01", STATE, {CW, CCW}); end
`else
        checks++; if (STATE !== 3'd1 || CCW !== 1'b1) begin errors++; $display("FAIL rev_swap state=%0d ccw=%b exp 1/1", STATE, CCW); end
`endif
        wait_edge(47 + DT);
        checks++; if (POWER !== 12'd48) begin errors++; $display("FAIL rev_up got=%0d exp=48", POWER); end
        wait_edge(48 + DT);
        checks++; if (POWER !== 12'd64 || STATE !== 3'd2) begin errors++; $display("FAIL rev_run power=%0d state=%0d exp 64/2", POWER, STATE); end
        checks++; if ({CW, CCW} !== 2'b01) begin errors++; $display("FAIL rev_run_dir got=%b exp=01", {CW, CCW}); end
    endtask

    task automatic test_fault;
        apply_reset();
        ENABLE = 1; TARGET = 64; DIR_REQ = 0;
        wait_edge(8);
        checks++; if (POWER !== 12'd32 || STATE !== 3'd1) begin errors++; $display("FAIL fault_pre power=%0d state=%0d exp 32/1", POWER, STATE); end
        FAULT_IN = 1;
        wait_edge(9);
        checks++; if (POWER !== 12'd0 || STATE !== 3'd5) begin errors++; $display("FAIL fault_enter power=%0d state=%0d exp 0/5", POWER, STATE); end
        checks++; if ({CW, CCW, BUSY} !== 3'b000) begin errors++; $display("FAIL fault_flags got=%b exp=000", {CW, CCW, BUSY}); end
        wait_edge(12);
        FAULT_IN = 0;
        wait_edge(14);
        checks++; if (STATE !== 3'd5) begin errors++; $display("FAIL fault_latch state=%0d exp=5", STATE); end
        ENABLE = 0;
        wait_edge(15);
        checks++; if (STATE !== 3'd0 || POWER !== 12'd0) begin errors++; $display("FAIL fault_exit state=%0d power=%0d exp 0/0", STATE, POWER); end
    endtask

    task automatic test_reset_midramp;
        apply_reset();
        ENABLE = 1; TARGET = 64; DIR_REQ = 0;
        wait_edge(12);
        checks++; if (POWER !== 12'd48) begin errors++; $display("FAIL mid_pre got=%0d exp=48", POWER); end
        #3;
        RESET = 1;
        #1;
        checks++; if (POWER !== 12'd0 || STATE !== 3'd0) begin errors++; $display("FAIL mid_async power=%0d state=%0d exp 0/0", POWER, STATE); end
        checks++; if ({CW, CCW, BUSY} !== 3'b000) begin errors++; $display("FAIL mid_async_flags got=%b exp=000", {CW, CCW, BUSY}); end
        @(posedge CLK);
        #1;
        RESET = 0;
        wait_edge(1);
        checks++; if (STATE !== 3'd1 || CW !== 1'b1) begin errors++; $display("FAIL mid_restart state=%0d cw=%b exp 1/1", STATE, CW); end
        wait_edge(3);
        checks++; if (POWER !== 12'd0) begin errors++; $display("FAIL mid_no_early got=%0d exp=0", POWER); end
        wait_edge(4);
        checks++; if (POWER !== 12'd16) begin errors++; $display("FAIL mid_first_tick got=%0d exp=16", POWER); end
    endtask

    task automatic test_disable;
        go_run64();
        ENABLE = 0;
        wait_edge(17);
        checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL dis_enter state=%0d exp=1", STATE); end
        wait_edge(28);
        checks++; if (POWER !== 12'd16 || CW !== 1'b1) begin errors++; $display("FAIL dis_down power=%0d cw=%b exp 16/1", POWER, CW); end
        wait_edge(32);
        checks++; if (POWER !== 12'd0 || STATE !== 3'd0) begin errors++; $display("FAIL dis_idle power=%0d state=%0d exp 0/0", POWER, STATE); end
        checks++; if ({CW, CCW, BUSY, AT_TARGET} !== 4'b0000) begin errors++; $display("FAIL dis_flags got=%b exp=0000", {CW, CCW, BUSY, AT_TARGET}); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_target_step();
        test_reverse();
        test_fault();
        test_reset_midramp();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
